// File: rtl/tuple_stream_source.sv
// Two-channel ready/valid tuple source: channel 0 streams base+n, channel 1 streams ~(base+n).
// Each channel handshakes independently; a sticky flag reports sinks that stall too long.
module tuple_stream_source #(
    parameter int WIDTH       = 5,
    parameter int COUNT_WIDTH = 8,
    parameter int TIMEOUT     = 3
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   START_valid,
    output logic                   START_ready,
    input  logic [COUNT_WIDTH-1:0] START_count,
    input  logic [WIDTH-1:0]       START_base,
    output logic [WIDTH-1:0]       OUTPUT_0_data,
    input  logic                   OUTPUT_0_ready,
    output logic                   OUTPUT_0_valid,
    output logic [WIDTH-1:0]       OUTPUT_1_data,
    input  logic                   OUTPUT_1_ready,
    output logic                   OUTPUT_1_valid,
    output logic                   BUSY,
    output logic                   DONE,
    output logic                   STALL_ERR
);

    // state  | meaning
    // S_IDLE | waiting for a start command, START_ready high
    // S_RUN  | channels streaming until both have sent count words
    // S_DONE | single-cycle completion pulse, then back to idle
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    // Stall counter must be able to hold TIMEOUT+1
    localparam int SW = $clog2(TIMEOUT + 2);

    state_t                 state;
    logic [COUNT_WIDTH-1:0] count_r;
    logic [WIDTH-1:0]       base_r;
    logic [COUNT_WIDTH-1:0] sent_0;
    logic [COUNT_WIDTH-1:0] sent_1;
    logic [SW-1:0]          stall_0;
    logic [SW-1:0]          stall_1;
    logic                   stall_err;

    logic                   valid_0;
    logic                   valid_1;
    logic                   xfer_0;
    logic                   xfer_1;
    logic [COUNT_WIDTH-1:0] sent_0_nxt;
    logic [COUNT_WIDTH-1:0] sent_1_nxt;
    logic [WIDTH-1:0]       word_0;
    logic [WIDTH-1:0]       word_1;

    assign valid_0    = (state == S_RUN) && (sent_0 != count_r);
    assign valid_1    = (state == S_RUN) && (sent_1 != count_r);
    assign xfer_0     = valid_0 && OUTPUT_0_ready;
    assign xfer_1     = valid_1 && OUTPUT_1_ready;
    assign sent_0_nxt = sent_0 + COUNT_WIDTH'(xfer_0);
    assign sent_1_nxt = sent_1 + COUNT_WIDTH'(xfer_1);
    assign word_0     = base_r + WIDTH'(sent_0);
    assign word_1     = base_r + WIDTH'(sent_1);

    // Data is forced to zero whenever the channel is not presenting a word
    assign OUTPUT_0_valid = valid_0;
    assign OUTPUT_1_valid = valid_1;
    assign OUTPUT_0_data  = valid_0 ? word_0 : '0;
    assign OUTPUT_1_data  = valid_1 ? ~word_1 : '0;

    assign START_ready = (state == S_IDLE);
    assign BUSY        = (state == S_RUN) || (state == S_DONE);
    assign DONE        = (state == S_DONE);
    assign STALL_ERR   = stall_err;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= S_IDLE;
            count_r   <= '0;
            base_r    <= '0;
            sent_0    <= '0;
            sent_1    <= '0;
            stall_0   <= '0;
            stall_1   <= '0;
            stall_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (START_valid) begin
                        count_r   <= START_count;
                        base_r    <= START_base;
                        sent_0    <= '0;
                        sent_1    <= '0;
                        stall_0   <= '0;
                        stall_1   <= '0;
                        stall_err <= 1'b0;
                        state     <= (START_count == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    sent_0 <= sent_0_nxt;
                    sent_1 <= sent_1_nxt;

                    if (valid_0 && !OUTPUT_0_ready) begin
                        if (stall_0 != SW'(TIMEOUT + 1))
                            stall_0 <= stall_0 + 1'b1;
                        if (stall_0 >= SW'(TIMEOUT))
                            stall_err <= 1'b1;
                    end else begin
                        stall_0 <= '0;
                    end

                    if (valid_1 && !OUTPUT_1_ready) begin
                        if (stall_1 != SW'(TIMEOUT + 1))
                            stall_1 <= stall_1 + 1'b1;
                        if (stall_1 >= SW'(TIMEOUT))
                            stall_err <= 1'b1;
                    end else begin
                        stall_1 <= '0;
                    end

                    if ((sent_0_nxt == count_r) && (sent_1_nxt == count_r))
                        state <= S_DONE;
                end
                S_DONE: begin
                    stall_0 <= '0;
                    stall_1 <= '0;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tuple_stream_source.sv
// Directed bench for tuple_stream_source: inputs driven and outputs checked on the falling edge.
module tb_tuple_stream_source;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       START_valid;
    logic       START_ready;
    logic [7:0] START_count;
    logic [4:0] START_base;
    logic [4:0] OUTPUT_0_data;
    logic       OUTPUT_0_ready;
    logic       OUTPUT_0_valid;
    logic [4:0] OUTPUT_1_data;
    logic       OUTPUT_1_ready;
    logic       OUTPUT_1_valid;
    logic       BUSY;
    logic       DONE;
    logic       STALL_ERR;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 CLK = ~CLK;

    tuple_stream_source #(.WIDTH(5), .COUNT_WIDTH(8), .TIMEOUT(3)) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .START_valid    (START_valid),
        .START_ready    (START_ready),
        .START_count    (START_count),
        .START_base     (START_base),
        .OUTPUT_0_data  (OUTPUT_0_data),
        .OUTPUT_0_ready (OUTPUT_0_ready),
        .OUTPUT_0_valid (OUTPUT_0_valid),
        .OUTPUT_1_data  (OUTPUT_1_data),
        .OUTPUT_1_ready (OUTPUT_1_ready),
        .OUTPUT_1_valid (OUTPUT_1_valid),
        .BUSY           (BUSY),
        .DONE           (DONE),
        .STALL_ERR      (STALL_ERR)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic check_out(input string tag, input int v0, input int d0, input int v1, input int d1);
        check({tag, ".v0"}, 32'(OUTPUT_0_valid), 32'(v0));
        check({tag, ".d0"}, 32'(OUTPUT_0_data), 32'(d0 & 31));
        check({tag, ".v1"}, 32'(OUTPUT_1_valid), 32'(v1));
        check({tag, ".d1"}, 32'(OUTPUT_1_data), 32'(d1 & 31));
    endtask

    // Checks the DONE cycle, then the following idle cycle.
    task automatic check_end(input string tag, input int err);
        check({tag, ".done"}, 32'(DONE), 32'd1);
        check({tag, ".busy"}, 32'(BUSY), 32'd1);
        check({tag, ".srdy_done"}, 32'(START_ready), 32'd0);
        check({tag, ".v0_done"}, 32'(OUTPUT_0_valid), 32'd0);
        check({tag, ".v1_done"}, 32'(OUTPUT_1_valid), 32'd0);
        check({tag, ".err_done"}, 32'(STALL_ERR), 32'(err));
        tick();
        check({tag, ".done_off"}, 32'(DONE), 32'd0);
        check({tag, ".busy_off"}, 32'(BUSY), 32'd0);
        check({tag, ".srdy_idle"}, 32'(START_ready), 32'd1);
    endtask

    task automatic start_cmd(input int cnt, input int base);
        START_valid = 1'b1;
        START_count = 8'(cnt);
        START_base  = 5'(base);
        tick();
        START_valid = 1'b0;
    endtask

    initial begin
        RESET          = 1'b1;
        START_valid    = 1'b0;
        START_count    = '0;
        START_base     = '0;
        OUTPUT_0_ready = 1'b1;
        OUTPUT_1_ready = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
        check_out("rst", 0, 0, 0, 0);
        check("rst.busy", 32'(BUSY), 32'd0);
        check("rst.done", 32'(DONE), 32'd0);
        check("rst.err", 32'(STALL_ERR), 32'd0);
        check("rst.srdy", 32'(START_ready), 32'd1);

        // count=4 base=3, both sinks always ready
        start_cmd(4, 3);
        for (int k = 0; k < 4; k++) begin
            check_out("t1", 1, 3 + k, 1, ~(3 + k));
            check("t1.srdy", 32'(START_ready), 32'd0);
            tick();
        end
        check_end("t1", 0);

        // wrap-around
        start_cmd(3, 30);
        check_out("t2a", 1, 30, 1, 1);
        tick();
        check_out("t2b", 1, 31, 1, 0);
        tick();
        check_out("t2c", 1, 0, 1, 31);
        tick();
        check_end("t2", 0);

        // channel 1 stalls two cycles, channel 0 finishes first
        OUTPUT_1_ready = 1'b0;
        start_cmd(2, 0);
        check_out("t3a", 1, 0, 1, 31);
        tick();
        check_out("t3b", 1, 1, 1, 31);
        tick();
        check_out("t3c", 0, 0, 1, 31);
        OUTPUT_1_ready = 1'b1;
        tick();
        check_out("t3d", 0, 0, 1, 30);
        check("t3.err", 32'(STALL_ERR), 32'd0);
        tick();
        check_end("t3", 0);

        // four stalled cycles trip the sticky error
        OUTPUT_1_ready = 1'b0;
        start_cmd(1, 0);
        check_out("t4a", 1, 0, 1, 31);
        tick();
        check_out("t4b", 0, 0, 1, 31);
        tick();
        tick();
        check("t4.err3", 32'(STALL_ERR), 32'd0);
        tick();
        check("t4.err4", 32'(STALL_ERR), 32'd1);
        check_out("t4e", 0, 0, 1, 31);
        OUTPUT_1_ready = 1'b1;
        tick();
        check_end("t4", 1);
        check("t4.err_idle", 32'(STALL_ERR), 32'd1);

        // count=0 goes straight to DONE and clears the error
        start_cmd(0, 9);
        check_out("t5", 0, 0, 0, 0);
        check_end("t5", 0);

        // START_valid during RUN is ignored
        start_cmd(3, 10);
        START_valid = 1'b1;
        START_count = 8'd0;
        START_base  = 5'd0;
        check_out("t6a", 1, 10, 1, ~10);
        tick();
        check_out("t6b", 1, 11, 1, ~11);
        check("t6.srdy", 32'(START_ready), 32'd0);
        tick();
        check_out("t6c", 1, 12, 1, ~12);
        START_valid = 1'b0;
        tick();
        check_end("t6", 0);

        // reset mid-sequence, then a fresh one-word run
        start_cmd(5, 0);
        tick();
        tick();
        check_out("t7pre", 1, 2, 1, ~2);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check_out("t7rst", 0, 0, 0, 0);
        check("t7.busy", 32'(BUSY), 32'd0);
        check("t7.srdy", 32'(START_ready), 32'd1);
        start_cmd(1, 7);
        check_out("t7a", 1, 7, 1, 24);
        tick();
        check_end("t7", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/tuple_stream_source.md
Name: tuple_stream_source

Overview:
- Transmitter end of the two-channel 5-bit ready/valid tuple interface that delay units consume and forward.
- On a start command it emits a programmed-length sequence on both channels:
  - OUTPUT_0 carries an incrementing sequence.
  - OUTPUT_1 carries the bitwise inverse of that sequence.
- Each channel has its own independent handshake.
- It flags any downstream sink that holds ready low beyond a bounded latency. This is the transmitter-side complement of the "valid implies ready within 3 cycles" property.

Parameters:
WIDTH, 5, data width of each output channel and of START_base
COUNT_WIDTH, 8, width of START_count (max words per channel = 2^COUNT_WIDTH-1)
TIMEOUT, 3, max consecutive cycles a channel may see valid=1 and ready=0 before STALL_ERR

Ports:
CLK  input  1  clock, all state updates on rising edge
RESET  input  1  synchronous, active-high reset
START_valid  input  1  start command valid
START_ready  output  1  block can accept a command (high only in IDLE)
START_count  input  COUNT_WIDTH  words to send per channel
START_base  input  WIDTH  first data value for channel 0
OUTPUT_0_data  output  WIDTH  channel 0 data
OUTPUT_0_ready  input  1  channel 0 sink ready
OUTPUT_0_valid  output  1  channel 0 data valid
OUTPUT_1_data  output  WIDTH  channel 1 data
OUTPUT_1_ready  input  1  channel 1 sink ready
OUTPUT_1_valid  output  1  channel 1 data valid
BUSY  output  1  high in RUN and DONE states
DONE  output  1  one-cycle pulse after both channels finish
STALL_ERR  output  1  sticky stall-timeout flag

Behaviour:
- Reset (RESET=1 at a rising edge, any state including mid-sequence): state=IDLE; all per-channel counters and stall counters cleared.
  - From the following cycle: OUTPUT_*_valid=0, OUTPUT_*_data=0, DONE=0, BUSY=0, STALL_ERR=0, START_ready=1.
- FSM states: IDLE, RUN, DONE.
  - IDLE: START_ready=1. A handshake (START_valid & START_ready at an edge) latches count and base, and clears STALL_ERR and both sent counters.
    - count!=0 -> RUN.
    - count==0 -> DONE; no output word is ever presented.
  - RUN: each channel c runs independently.
    - OUTPUT_c_valid=1 while sent_c < count.
    - OUTPUT_0_data = (base + sent_0) mod 2^WIDTH.
    - OUTPUT_1_data = ~((base + sent_1) mod 2^WIDTH).
  - RUN -> DONE on the edge where the last outstanding handshake completes. If both channels' final handshakes happen at the same edge, the transition happens at that edge.
  - DONE: lasts exactly one cycle; DONE=1, START_ready=0, valids=0; then -> IDLE.
- First-word latency: the first words are presented (valid=1) in the cycle immediately after START is accepted.
- Handshake rules per channel:
  - A transfer occurs at an edge where valid=1 and ready=1; sent_c increments.
  - The next word appears the following cycle with valid held high. Back-to-back transfers with ready=1 run at one word per cycle, no bubbles.
  - While valid=1 and ready=0, data and valid hold stable. Valid never drops without a transfer, except on reset.
  - Valid does not depend combinationally on ready. Ready may be high while valid=0; this has no effect.
  - After a channel's final transfer its valid=0 while the other channel may still be sending.
- Arithmetic: base+sent is truncated to WIDTH bits, so data wraps (31 -> 0 for WIDTH=5). sent_c is COUNT_WIDTH bits and never exceeds count.
- Stall detection per channel:
  - stall_c counts consecutive cycles with valid_c=1 and ready_c=0; it clears on any transfer or when valid_c=0.
  - When stall_c reaches TIMEOUT+1, STALL_ERR sets on that edge (saturating).
  - STALL_ERR stays set until RESET or the next START accept. Transmission is not aborted.
- START_valid outside IDLE is ignored.

Test Plan:
- Reset then START(count=4, base=3), both ready=1 -> channel 0 data 3,4,5,6 and channel 1 data 28,27,26,25 on four consecutive cycles; DONE pulses the cycle after the 4th transfer; START_ready=1 the cycle after that.
- START(count=3, base=30), ready=1 -> channel 0 data 30,31,0 (wrap); channel 1 data 1,0,31.
- START(count=2, base=0); OUTPUT_0_ready=1, OUTPUT_1_ready low for 2 cycles then high -> channel 0 finishes first with valid_0=0 afterwards; channel 1 data held at 31 during the stall; DONE one cycle after channel 1's last transfer; STALL_ERR stays 0.
- OUTPUT_1_ready held low 4 cycles with TIMEOUT=3 -> STALL_ERR=1 after the 4th stalled cycle and stays 1 through DONE; the next START accept clears it.
- START(count=0) -> no valid ever asserted; DONE=1 in the cycle after accept; START_valid asserted during RUN is ignored.
- RESET=1 mid-RUN after 2 of 5 words -> the next cycle shows valids=0, BUSY=0, START_ready=1; a new START(count=1, base=7) sends 7 and 24.
